// File: rtl/jtframe_db15_pkg.sv
// Shared types and constants for the DB15 serial joystick responder.
// Holds the frame width default, the responder state encoding and the
// debounce stability length.
package jtframe_db15_pkg;

    // Two 16-bit joystick words per frame
    localparam int FRAME_BITS_DEF = 32;

    // Consecutive prescaler ticks at a new level before a button changes
    localparam int DEB_STABLE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } db15_st_t;

    // Serial frame as seen on the wire: buttons are active-low and
    // joystick 2 occupies the upper half so its MSB goes out first.
    function automatic logic [31:0] frame_word(input logic [15:0] j1,
                                               input logic [15:0] j2);
        return {~j2, ~j1};
    endfunction

endpackage

// File: rtl/jtframe_db15_deb.sv
// Button debouncer for the DB15 responder.
// A shared prescaler produces a tick every DEB_TICK cycles; each input bit
// keeps a 2-bit count of consecutive ticks that sampled a level different
// from its filtered value, and the filtered value follows only after
// DEB_STABLE such ticks in a row. Filtered values start released (0).
module jtframe_db15_deb
    import jtframe_db15_pkg::*;
#(
    parameter int W        = 32,
    parameter int DEB_TICK = 1024
)(
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] filt_o
);

    localparam int PW = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick;

    // Prescaler wraps after DEB_TICK cycles and flags the wrap as a tick
    always_comb begin
        tick  = (pre_q == PW'(DEB_TICK - 1));
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Prescaler register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic [1:0] cnt_q;
        logic [1:0] cnt_d;
        logic       filt_q;
        logic       filt_d;

        // Count ticks that disagree with the filtered level; any agreeing
        // tick restarts the run so only an unbroken run can flip the bit
        always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            if (tick) begin
                if (raw_i[gi] == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == 2'(DEB_STABLE - 1)) begin
                    filt_d = raw_i[gi];
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
        end

        // Per-bit stability counter and filtered value
        always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign filt_o[gi] = filt_q;
    end

endmodule

// File: rtl/jtframe_db15_tx.sv
// Device-side DB15 serial joystick responder.
// Emulates a 74HC165-style parallel-in/serial-out chain: the host pulls
// JOY_LOAD low to capture both joysticks, then each JOY_CLK rising edge
// presents the next bit on JOY_DATA (MSB first, active-low buttons).
// Host strobes are asynchronous and pass through 2-flop synchronizers.
// Optional build macro: JTFRAME_DB15_DEBOUNCE_EN adds a per-button debouncer
// in front of the capture; without it the buttons are registered once.
module jtframe_db15_tx
    import jtframe_db15_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int DEB_TICK   = 1024
)(
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    input  logic        JOY_LOAD,
    input  logic        JOY_CLK,
    output logic        JOY_DATA,
    output logic        busy,
    output logic        frame_done,
    output logic        short_frame
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    // Buttons as presented to the capture logic, active-high
    logic [31:0] btn_w;

`ifdef JTFRAME_DB15_DEBOUNCE_EN
    jtframe_db15_deb #(
        .W        (32),
        .DEB_TICK (DEB_TICK)
    ) u_deb (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .raw_i   ({joy2, joy1}),
        .filt_o  (btn_w)
    );
`else
    logic [31:0] joy_q;

    // Single register stage between the button pins and the capture
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) joy_q <= '0;
        else        joy_q <= {joy2, joy1};
    end

    assign btn_w = joy_q;
`endif

    // ------------------------------------------------------------------
    // Host strobe synchronizers
    // ------------------------------------------------------------------
    // JOY_LOAD needs only its level; JOY_CLK gets a third stage so a rising
    // edge can be seen between stages 1 and 2 of the synchronized copy.
    logic [1:0] load_sync_q;
    logic [2:0] clk_sync_q;
    logic       load_low;
    logic       clk_rise;

    // Synchronizer chains, reset to the idle pin levels
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            load_sync_q <= 2'b11;
            clk_sync_q  <= 3'b000;
        end else begin
            load_sync_q <= {load_sync_q[0], JOY_LOAD};
            clk_sync_q  <= {clk_sync_q[1:0], JOY_CLK};
        end
    end

    assign load_low = ~load_sync_q[1];
    assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];

    // ------------------------------------------------------------------
    // Responder FSM and shift register
    // ------------------------------------------------------------------
    db15_st_t              state_q;
    db15_st_t              state_d;
    logic [FRAME_BITS-1:0] sr_q;
    logic [FRAME_BITS-1:0] sr_d;
    logic [CW-1:0]         bit_cnt_q;
    logic [CW-1:0]         bit_cnt_d;
    logic                  frame_done_q;
    logic                  frame_done_d;
    logic                  short_frame_q;
    logic                  short_frame_d;
    logic [FRAME_BITS-1:0] frame_w;

    assign frame_w = FRAME_BITS'(frame_word(btn_w[15:0], btn_w[31:16]));

    // Next-state logic: a synchronized load always takes priority over a
    // shift edge seen in the same cycle, so a shift is never half-applied.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_low) begin
                    state_d   = LOAD;
                    sr_d      = frame_w;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                // Keep tracking the buttons until the host releases load
                if (load_low) begin
                    sr_d = frame_w;
                end else begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (load_low) begin
                    state_d       = LOAD;
                    sr_d          = frame_w;
                    bit_cnt_d     = '0;
                    // bit_cnt never reaches FRAME_BITS while in SHIFT
                    short_frame_d = (bit_cnt_q != '0);
                end else if (clk_rise) begin
                    sr_d      = {sr_q[FRAME_BITS-2:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                // Frame fully consumed: extra clocks only push more 1s and
                // the counter stays saturated at FRAME_BITS
                if (load_low) begin
                    state_d   = LOAD;
                    sr_d      = frame_w;
                    bit_cnt_d = '0;
                end else if (clk_rise) begin
                    sr_d = {sr_q[FRAME_BITS-2:0], 1'b1};
                end
            end
            default: begin
                state_d   = IDLE;
                sr_d      = '1;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State, shift register, counter and pulse registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sr_q          <= '1;
            bit_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
        end
    end

    // The shift register idles at all 1s, so its MSB is the idle level too
    assign JOY_DATA    = sr_q[FRAME_BITS-1];
    assign busy        = (state_q == SHIFT) && (bit_cnt_q != '0);
    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;

endmodule
